// File: rtl/opl3_sample_mixer.sv
`default_nettype none
// ============================================================================
// Module   : opl3_sample_mixer
// Purpose  : Sums per-channel samples into left/right, then saturates and
//            presents one stereo pair per sample period.
// Revision : 1.0 - initial release
// ============================================================================
module opl3_sample_mixer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int NUM_CHANNELS = 18,
  parameter int ACC_WIDTH    = SAMPLE_WIDTH + $clog2(NUM_CHANNELS) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sample_clk_en,
  input  logic                           ch_valid,
  input  logic signed [SAMPLE_WIDTH-1:0] ch_sample,
  input  logic                           ch_left_en,
  input  logic                           ch_right_en,
  output logic signed [SAMPLE_WIDTH-1:0] left_channel,
  output logic signed [SAMPLE_WIDTH-1:0] right_channel,
  output logic                           sample_valid,
  output logic                           clip,
  output logic                           ch_count_err
);

  localparam int c_CNT_W = $clog2(NUM_CHANNELS) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [c_CNT_W-1:0] c_CNT_EXP = c_CNT_W'(NUM_CHANNELS);
  localparam logic signed [ACC_WIDTH-1:0] c_SAT_MAX =
    {{(ACC_WIDTH-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] c_SAT_MIN =
    {{(ACC_WIDTH-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};
  localparam logic signed [SAMPLE_WIDTH-1:0] c_OUT_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [SAMPLE_WIDTH-1:0] c_OUT_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0]    w_ext;
  logic signed [ACC_WIDTH-1:0]    w_add_l;
  logic signed [ACC_WIDTH-1:0]    w_add_r;
  logic        [c_CNT_W-1:0]      w_cnt_inc;
  logic        [c_CNT_W-1:0]      w_cnt_load;

  logic signed [ACC_WIDTH-1:0]    r_acc_l;
  logic signed [ACC_WIDTH-1:0]    r_acc_r;
  logic        [c_CNT_W-1:0]      r_cnt;

  logic                           r_s1_vld;
  logic signed [ACC_WIDTH-1:0]    r_snap_l;
  logic signed [ACC_WIDTH-1:0]    r_snap_r;
  logic        [c_CNT_W-1:0]      r_snap_cnt;

  logic signed [SAMPLE_WIDTH-1:0] w_sat_l;
  logic signed [SAMPLE_WIDTH-1:0] w_sat_r;
  logic                           w_clip_l;
  logic                           w_clip_r;

  logic signed [SAMPLE_WIDTH-1:0] r_left;
  logic signed [SAMPLE_WIDTH-1:0] r_right;
  logic                           r_valid;
  logic                           r_clip;
  logic                           r_cnt_err;

  assign w_ext      = {{(ACC_WIDTH-SAMPLE_WIDTH){ch_sample[SAMPLE_WIDTH-1]}}, ch_sample};
  assign w_add_l    = (ch_valid && ch_left_en)  ? w_ext : '0;
  assign w_add_r    = (ch_valid && ch_right_en) ? w_ext : '0;
  assign w_cnt_inc  = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_cnt_load = {{(c_CNT_W-1){1'b0}}, ch_valid};

  // A contribution arriving on the boundary cycle opens the new period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc_l <= '0;
      r_acc_r <= '0;
      r_cnt   <= '0;
    end else if (sample_clk_en) begin
      r_acc_l <= w_add_l;
      r_acc_r <= w_add_r;
      r_cnt   <= w_cnt_load;
    end else begin
      r_acc_l <= r_acc_l + w_add_l;
      r_acc_r <= r_acc_r + w_add_r;
      if (ch_valid) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_vld   <= 1'b0;
      r_snap_l   <= '0;
      r_snap_r   <= '0;
      r_snap_cnt <= '0;
    end else begin
      r_s1_vld <= sample_clk_en;
      if (sample_clk_en) begin
        r_snap_l   <= r_acc_l;
        r_snap_r   <= r_acc_r;
        r_snap_cnt <= r_cnt;
      end
    end
  end

  always_comb begin
    w_sat_l  = r_snap_l[SAMPLE_WIDTH-1:0];
    w_clip_l = 1'b0;
    if (r_snap_l > c_SAT_MAX) begin
      w_sat_l  = c_OUT_MAX;
      w_clip_l = 1'b1;
    end else if (r_snap_l < c_SAT_MIN) begin
      w_sat_l  = c_OUT_MIN;
      w_clip_l = 1'b1;
    end
  end

  always_comb begin
    w_sat_r  = r_snap_r[SAMPLE_WIDTH-1:0];
    w_clip_r = 1'b0;
    if (r_snap_r > c_SAT_MAX) begin
      w_sat_r  = c_OUT_MAX;
      w_clip_r = 1'b1;
    end else if (r_snap_r < c_SAT_MIN) begin
      w_sat_r  = c_OUT_MIN;
      w_clip_r = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_left    <= '0;
      r_right   <= '0;
      r_valid   <= 1'b0;
      r_clip    <= 1'b0;
      r_cnt_err <= 1'b0;
    end else begin
      r_valid   <= r_s1_vld;
      r_cnt_err <= 1'b0;
      if (r_s1_vld) begin
        r_left    <= w_sat_l;
        r_right   <= w_sat_r;
        r_clip    <= r_clip | w_clip_l | w_clip_r;
        r_cnt_err <= (r_snap_cnt != c_CNT_EXP);
      end
    end
  end

  assign left_channel  = r_left;
  assign right_channel = r_right;
  assign sample_valid  = r_valid;
  assign clip          = r_clip;
  assign ch_count_err  = r_cnt_err;

endmodule
`default_nettype wire

// File: tb/tb_opl3_sample_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_opl3_sample_mixer
// Purpose  : Directed stimulus with a queued scoreboard for opl3_sample_mixer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opl3_sample_mixer;

  logic               clk = 1'b0;
  logic               reset;
  logic               sample_clk_en;
  logic               ch_valid;
  logic signed [15:0] ch_sample;
  logic               ch_left_en;
  logic               ch_right_en;
  logic signed [15:0] left_channel;
  logic signed [15:0] right_channel;
  logic               sample_valid;
  logic               clip;
  logic               ch_count_err;

  typedef struct {
    logic signed [15:0] l;
    logic signed [15:0] r;
    logic               err;
    logic               clp;
    int                 cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  opl3_sample_mixer dut (
    .clk           (clk),
    .reset         (reset),
    .sample_clk_en (sample_clk_en),
    .ch_valid      (ch_valid),
    .ch_sample     (ch_sample),
    .ch_left_en    (ch_left_en),
    .ch_right_en   (ch_right_en),
    .left_channel  (left_channel),
    .right_channel (right_channel),
    .sample_valid  (sample_valid),
    .clip          (clip),
    .ch_count_err  (ch_count_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_sample_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("latency_cycle", cyc, e.cyc);
        check("left_channel", int'(left_channel), int'(e.l));
        check("right_channel", int'(right_channel), int'(e.r));
        check("ch_count_err", int'(ch_count_err), int'(e.err));
        check("clip", int'(clip), int'(e.clp));
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      check("missing_sample_valid", 0, 1);
      void'(q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic contrib(input int n, input logic signed [15:0] v, input logic l, input logic r);
    repeat (n) begin
      ch_valid    = 1'b1;
      ch_sample   = v;
      ch_left_en  = l;
      ch_right_en = r;
      step();
    end
    ch_valid = 1'b0;
  endtask

  task automatic boundary(input logic push, input logic signed [15:0] l, input logic signed [15:0] r,
                          input logic err, input logic clp,
                          input logic with_c, input logic signed [15:0] v);
    exp_t e;
    e.l = l; e.r = r; e.err = err; e.clp = clp; e.cyc = cyc + 2;
    if (push) q.push_back(e);
    sample_clk_en = 1'b1;
    ch_valid      = with_c;
    ch_sample     = v;
    ch_left_en    = 1'b1;
    ch_right_en   = 1'b1;
    step();
    sample_clk_en = 1'b0;
    ch_valid      = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    @(negedge clk);
    check({tag, "_left"},  int'(left_channel), 0);
    check({tag, "_right"}, int'(right_channel), 0);
    check({tag, "_valid"}, int'(sample_valid), 0);
    check({tag, "_clip"},  int'(clip), 0);
    check({tag, "_err"},   int'(ch_count_err), 0);
    #1;
  endtask

  initial begin
    reset = 1'b0; sample_clk_en = 1'b0; ch_valid = 1'b1; ch_sample = 16'sd1234;
    ch_left_en = 1'b1; ch_right_en = 1'b1;
    // Reset held with activity and boundary pulses; the last one must be flushed.
    for (int i = 0; i < 3; i++) begin
      sample_clk_en = (i != 0);
      step();
    end
    check_idle_zero("reset");
    reset = 1'b1; sample_clk_en = 1'b0; ch_valid = 1'b0;
    step();

    contrib(18, 16'sd1000, 1'b1, 1'b0);
    boundary(1'b1, 16'sd18000, 16'sd0, 1'b0, 1'b0, 1'b0, 16'sd0);

    contrib(18, 16'sd32767, 1'b1, 1'b1);
    boundary(1'b1, 16'sd32767, 16'sd32767, 1'b0, 1'b1, 1'b0, 16'sd0);

    contrib(18, 16'sd0, 1'b1, 1'b1);
    boundary(1'b1, 16'sd0, 16'sd0, 1'b0, 1'b1, 1'b0, 16'sd0);

    contrib(10, -16'sd5000, 1'b1, 1'b1);
    boundary(1'b1, 16'sh8000, 16'sh8000, 1'b1, 1'b1, 1'b0, 16'sd0);

    contrib(9, 16'sd100, 1'b1, 1'b0);
    contrib(9, -16'sd100, 1'b0, 1'b1);
    boundary(1'b1, 16'sd900, -16'sd900, 1'b0, 1'b1, 1'b0, 16'sd0);

    // +7 on the boundary cycle belongs to the following period.
    contrib(18, 16'sd5, 1'b1, 1'b1);
    boundary(1'b1, 16'sd90, 16'sd90, 1'b0, 1'b1, 1'b1, 16'sd7);
    contrib(17, 16'sd0, 1'b1, 1'b1);
    boundary(1'b1, 16'sd7, 16'sd7, 1'b0, 1'b1, 1'b0, 16'sd0);

    contrib(17, 16'sd1, 1'b1, 1'b0);
    boundary(1'b1, 16'sd17, 16'sd0, 1'b1, 1'b1, 1'b0, 16'sd0);
    boundary(1'b1, 16'sd0, 16'sd0, 1'b1, 1'b1, 1'b0, 16'sd0);
    repeat (3) step();

    // Reset one cycle after a boundary: its stage 2 never completes.
    contrib(18, 16'sd50, 1'b1, 1'b0);
    boundary(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0, 1'b0, 16'sd0);
    reset = 1'b0;
    step();
    step();
    check_idle_zero("midreset");
    reset = 1'b1;
    step();

    contrib(18, -16'sd1, 1'b0, 1'b1);
    boundary(1'b1, 16'sd0, -16'sd18, 1'b0, 1'b0, 1'b0, 16'sd0);

    repeat (6) step();
    check("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/opl3_sample_mixer.md
Name: opl3_sample_mixer

Overview:
- Upstream stage of the I2S transmitter.
- Accumulates per-channel signed samples produced sequentially by the channel pipeline during one sample period into separate left and right sums.
- At each sample boundary, saturates each sum to SAMPLE_WIDTH and presents the stereo pair with a delayed strobe that the I2S stage captures.
- Also reports clipping and channel-count anomalies for debug.

Parameters:
- SAMPLE_WIDTH, 16: width of the input channel samples and of the output samples. Signed, two's complement.
- NUM_CHANNELS, 18: expected number of channel contributions per sample period.
- ACC_WIDTH, SAMPLE_WIDTH+$clog2(NUM_CHANNELS)+1 (default 22): accumulator width. Cannot overflow for NUM_CHANNELS full-scale inputs.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset. reset==0 at a clk edge resets the block.
- sample_clk_en  input  1  one-cycle pulse marking the sample-period boundary.
- ch_valid  input  1  ch_sample is valid this cycle.
- ch_sample  input  SAMPLE_WIDTH  signed channel output.
- ch_left_en  input  1  route this contribution to the left sum.
- ch_right_en  input  1  route this contribution to the right sum.
- left_channel  output  SAMPLE_WIDTH  saturated left sample.
- right_channel  output  SAMPLE_WIDTH  saturated right sample.
- sample_valid  output  1  one-cycle strobe; left_channel/right_channel are new and stable from this cycle onward.
- clip  output  1  sticky: set when any output was saturated; cleared only by reset.
- ch_count_err  output  1  one-cycle pulse with sample_valid when the finished period's contribution count != NUM_CHANNELS.

Behaviour:
- Reset values: left_channel=0, right_channel=0, sample_valid=0, clip=0, ch_count_err=0. Accumulators and ch_count=0.
- Accumulate (clk edge, no boundary):
  - If ch_valid: sign-extend ch_sample to ACC_WIDTH.
  - If ch_left_en, add it to acc_l. If ch_right_en, add it to acc_r. Both may be set; neither set means the contribution is counted but not summed.
  - ch_count increments on every ch_valid and saturates at 2^($clog2(NUM_CHANNELS)+1)-1.
- Boundary (sample_clk_en=1):
  - Snapshot acc_l, acc_r and ch_count.
  - Reload acc_l/acc_r/ch_count with this cycle's contribution if ch_valid is high, otherwise 0. A same-cycle contribution belongs to the NEW period and is never lost.
  - Pipeline stage 1 (same edge): the snapshot is registered.
  - Stage 2 (next edge): saturate each snapshot.
    - If value > 2^(SAMPLE_WIDTH-1)-1, output 32767 (default width).
    - If value < -2^(SAMPLE_WIDTH-1), output -32768.
    - Otherwise truncate to SAMPLE_WIDTH.
  - Stage 2 also writes left_channel/right_channel and asserts sample_valid for exactly one cycle.
  - clip is set if either channel saturated. ch_count_err pulses if the snapshot count != NUM_CHANNELS.
- Latency: sample_valid is high exactly 2 clk cycles after the sample_clk_en cycle. Outputs hold until the next sample_valid.
- Connection rule: the downstream I2S stage's sample_clk_en is driven by sample_valid, not by the raw sample_clk_en.
- Back-to-back boundaries:
  - sample_clk_en pulses 1 cycle apart are legal. Each produces its own sample_valid in order.
  - The middle period is empty: sums 0, and ch_count_err=1 if NUM_CHANNELS>0.
- Reset mid-operation: reset overrides everything on that edge.
  - The pipeline is flushed. No sample_valid is produced for a boundary whose stage 2 has not completed.
  - Accumulators and clip clear.
- No backpressure: downstream must accept every sample_valid.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with ch_valid=1 and sample_clk_en pulses -> all outputs 0, no sample_valid. Release -> the first boundary yields sums of only post-reset contributions.
- Basic mix: 18 contributions of +1000, left only; then sample_clk_en -> 2 cycles later left_channel=18000, right_channel=0, sample_valid=1 for 1 cycle, ch_count_err=0, clip=0.
- Positive clip: 18×+32767 on both channels -> left=right=32767, clip=1 and stays 1 over following clean periods until reset.
- Negative clip and mixed routing:
  - 10×-5000 on both channels -> left=right=-32768, clip=1.
  - Next period: 9×+100 left, 9×-100 right -> left=900, right=-900, ch_count_err=0.
- Boundary collision: ch_valid=1 with +7 on both in the same cycle as sample_clk_en -> the old period excludes 7. The next period includes 7; with 17 more contributions of 0, the next output is 7/7 with ch_count_err=0.
- Count error and back-to-back: period of 17 contributions -> ch_count_err pulse. Two sample_clk_en pulses 1 cycle apart -> two sample_valid pulses 1 cycle apart, the second with outputs 0 and ch_count_err=1.
